// File: rtl/fifo_upsizer.sv
// Pops RATIO narrow words from a non-fall-through FIFO and packs them into one wide valid/ready beat.
// A flush emits a partial beat with a lane mask. Define FIFO_UPSIZER_STATS_EN to enable the beats_o counter.
module fifo_upsizer #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4,
  parameter int CNT_W      = $clog2(RATIO) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]       fifo_data_i,
  output logic                        fifo_pop_o,
  input  logic                        flush_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DATA_WIDTH*RATIO-1:0] data_o,
  output logic [RATIO-1:0]            keep_o,
  output logic [31:0]                 beats_o
);

  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_n;
  logic [DATA_WIDTH*RATIO-1:0] pack_q, pack_d;
  logic [RATIO-1:0]            keep_q, keep_d;
  logic                        pop_ok;

  // In SEND a pop is only allowed when the current beat leaves this cycle.
  assign pop_ok     = ~fifo_empty_i & ((state_q == FILL) | ready_i);
  assign fifo_pop_o = pop_ok & ~rst_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    keep_d  = keep_q;
    cnt_n   = cnt_q + {{(CNT_W-1){1'b0}}, pop_ok};

    if (state_q == FILL) begin
      if (pop_ok) begin
        for (int k = 0; k < RATIO; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            pack_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_data_i;
            keep_d[k]                          = 1'b1;
          end
        end
        cnt_d = cnt_n;
      end
      if (cnt_n == CNT_W'(RATIO)) begin
        state_d = SEND;
      end else if (flush_i && (cnt_n != '0)) begin
        state_d = SEND;
      end
    end else if (ready_i) begin
      // Beat leaves; a word popped in the same cycle starts the next beat in lane 0.
      state_d = FILL;
      pack_d  = '0;
      keep_d  = '0;
      cnt_d   = '0;
      if (pop_ok) begin
        pack_d[DATA_WIDTH-1:0] = fifo_data_i;
        keep_d[0]              = 1'b1;
        cnt_d                  = CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pack_q  <= '0;
      keep_q  <= '0;
    end else if (clr_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pack_q  <= '0;
      keep_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      keep_q  <= keep_d;
    end
  end

  assign valid_o = (state_q == SEND);
  assign data_o  = pack_q;
  assign keep_o  = keep_q;

`ifdef FIFO_UPSIZER_STATS_EN
  logic [31:0] beats_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beats_q <= '0;
    end else if (clr_i) begin
      beats_q <= '0;
    end else if (valid_o && ready_i && (beats_q != 32'hFFFF_FFFF)) begin
      beats_q <= beats_q + 32'd1;
    end
  end

  assign beats_o = beats_q;
`else
  assign beats_o = '0;
`endif

endmodule
